// File: rtl/fpu_lzd_pipelined.sv
// Pipelined leading-zero / leading-one detector.
// Binary priority tree with a register after every PIPE_EVERY layers.
module fpu_lzd_pipelined #(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 2,
  parameter int TAG_W      = 4
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_lead_one,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH):0]     out_count,
  output logic                       out_all,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int LOG2W  = $clog2(WIDTH);
  localparam int STAGES = (LOG2W + PIPE_EVERY - 1) / PIPE_EVERY;
  localparam int CW     = LOG2W + 1;

  typedef logic [WIDTH-1:0][LOG2W-1:0] pos_t;

  // Tree level: node i is {v[i], p[i]}; unused nodes stay zero.
  typedef struct packed {
    logic [WIDTH-1:0] v;
    pos_t             p;
  } node_t;

  // One merge layer k: upper half of each pair wins when valid.
  function automatic node_t merge_layer(input node_t a, input int k);
    node_t r;
    r = '0;
    for (int i = 0; i < WIDTH / 2; i++) begin
      if (i < (WIDTH >> (k + 1))) begin
        r.v[i]    = a.v[2*i+1] | a.v[2*i];
        r.p[i]    = a.v[2*i+1] ? a.p[2*i+1] : a.p[2*i];
        r.p[i][k] = ~a.v[2*i+1];
      end
    end
    return r;
  endfunction

  function automatic node_t apply_layers(
    input node_t a,
    input int    first,
    input int    last
  );
    node_t n;
    n = a;
    for (int k = 0; k < LOG2W; k++) begin
      if (k >= first && k <= last) n = merge_layer(n, k);
    end
    return n;
  endfunction

  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   rdy;
  node_t             node_q [STAGES];
  node_t             node_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic              init_q;
  node_t             fin;

  // In-ready comes up one edge after reset release.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) init_q <= 1'b0;
    else        init_q <= 1'b1;
  end

  // Backward ready chain: a stage loads when empty or draining.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy[s] = ~vld_q[s] | rdy[s+1];
    end
  end

  assign in_ready = init_q & ~flush & rdy[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int FIRST = s * PIPE_EVERY;
    localparam int LAST  =
      ((FIRST + PIPE_EVERY) < LOG2W ? FIRST + PIPE_EVERY : LOG2W) - 1;

    node_t            src;
    logic             src_v;
    logic [TAG_W-1:0] src_t;
    logic             v_q;
    node_t            n_q;
    logic [TAG_W-1:0] t_q;

    if (s == 0) begin : g_in
      assign src   = {in_data ^ {WIDTH{in_lead_one}}, pos_t'(0)};
      assign src_v = in_valid & in_ready;
      assign src_t = in_tag;
    end else begin : g_mid
      assign src   = node_q[s-1];
      assign src_v = vld_q[s-1];
      assign src_t = tag_q[s-1];
    end

    assign node_d[s] = apply_layers(src, FIRST, LAST);

    // Stage register: flush clears, stall holds, else advance.
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        v_q <= 1'b0;
        n_q <= '0;
        t_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (rdy[s]) begin
        v_q <= src_v;
        if (src_v) begin
          n_q <= node_d[s];
          t_q <= src_t;
        end
      end
    end

    assign vld_q[s]  = v_q;
    assign node_q[s] = n_q;
    assign tag_q[s]  = t_q;
  end

  assign fin       = node_q[STAGES-1];
  assign out_valid = vld_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_all   = out_valid & ~fin.v[0];

  // Result count: run length, or WIDTH when no terminating bit.
  always_comb begin
    out_count = '0;
    if (out_valid) begin
      out_count = fin.v[0] ? {1'b0, fin.p[0]} : CW'(WIDTH);
    end
  end

endmodule

// File: tb/tb_fpu_lzd_pipelined.sv
// Bench for fpu_lzd_pipelined: scoreboard on a 32/2 instance
// plus a latency/count sweep over WIDTH x PIPE_EVERY.
module tb_fpu_lzd_pipelined;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int LW = 5;
  localparam int ST = 3;

  logic          clk = 1'b0;
  logic          rst_l, flush, in_valid, in_ready, in_lead_one;
  logic          out_valid, out_ready, out_all;
  logic [W-1:0]  in_data;
  logic [TW-1:0] in_tag, out_tag;
  logic [LW:0]   out_count;
  logic          sw_rst_l;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;
  int sweep_done = 0;
  bit lat_exact, chk_ready, bp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_lzd_pipelined #(.WIDTH(W), .PIPE_EVERY(2), .TAG_W(TW)) u_dut (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_lead_one(in_lead_one), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_all(out_all), .out_tag(out_tag)
  );

  // Reference: scan from the MSB while bits equal the run value.
  function automatic int ref_lz(input logic [63:0] d, input int w,
                                input bit lo);
    int n;
    n = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i] != lo) return n;
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int            cnt;
    bit            all;
    logic [TW-1:0] tag;
    int            c;
  } exp_t;

  exp_t q[$];
  logic prev_hold = 1'b0;
  logic [LW:0] p_cnt;
  logic p_all;
  logic [TW-1:0] p_tag;

  // Compare process: scoreboard, hold stability, in_ready rule.
  always @(negedge clk) begin
    if (rst_l !== 1'b1) begin
      q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_count", out_count, p_cnt);
        chk("hold_all", out_all, p_all);
        chk("hold_tag", out_tag, p_tag);
      end
      if (chk_ready && !flush)
        chk("in_ready_rule", in_ready,
            !(q.size() == ST && !out_ready));
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (q.size() == 0) begin
            chk("unexpected_out", out_valid, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("count", out_count, e.cnt);
            chk("all", out_all, e.all);
            chk("tag", out_tag, e.tag);
            if (lat_exact) chk("latency", cyc - e.c, ST);
          end
        end
        if (in_valid && in_ready) begin
          exp_t e;
          e.cnt = ref_lz({32'h0, in_data}, W, in_lead_one);
          e.all = (e.cnt == W);
          e.tag = in_tag;
          e.c   = cyc;
          q.push_back(e);
        end
      end
      prev_hold = out_valid && !out_ready && !flush;
      p_cnt = out_count;
      p_all = out_all;
      p_tag = out_tag;
    end
  end

  always @(posedge clk) begin
    if (bp) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit lo,
                      input logic [3:0] t);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_lead_one = lo;
    in_tag = t;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_accept", 0, 1);
  endtask

  task automatic directed(input string nm, input logic [31:0] d,
                          input bit lo, input logic [3:0] t,
                          input int ec, input bit ea);
    int k;
    send(d, lo, t);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    chk({nm, "_latency"}, k, 3);
    chk({nm, "_count"}, out_count, ec);
    chk({nm, "_all"}, out_all, ea);
    chk({nm, "_tag"}, out_tag, t);
    tick();
  endtask

  // Parameter sweep: one operand at a time, out_ready tied high.
  for (genvar wi = 0; wi < 4; wi++) begin : g_w
    for (genvar pe = 1; pe <= 6; pe++) begin : g_pe
      localparam int SW = 8 << wi;
      localparam int SL = $clog2(SW);
      if (pe <= SL) begin : g_on
        localparam int SS = (SL + pe - 1) / pe;
        logic          iv, ir, ilo, ov, oa;
        logic [SW-1:0] id;
        logic [3:0]    it, ot;
        logic [SL:0]   oc;

        fpu_lzd_pipelined #(.WIDTH(SW), .PIPE_EVERY(pe), .TAG_W(4)) u_sw (
          .clk(clk), .rst_l(sw_rst_l), .flush(1'b0),
          .in_valid(iv), .in_ready(ir), .in_data(id),
          .in_lead_one(ilo), .in_tag(it),
          .out_valid(ov), .out_ready(1'b1),
          .out_count(oc), .out_all(oa), .out_tag(ot)
        );

        initial begin
          iv = 1'b0;
          id = '0;
          ilo = 1'b0;
          it = '0;
          wait (sw_rst_l === 1'b1);
          tick();
          for (int m = 0; m < 2; m++) begin
            for (int n = 0; n <= SW; n++) begin
              logic [63:0] d;
              int lat, ec;
              bit lb;
              lb = (m == 1);
              d = {$urandom, $urandom};
              for (int b = 0; b < SW; b++)
                if (b > SW - 1 - n) d[b] = lb;
              if (n < SW) d[SW-1-n] = ~lb;
              ec = ref_lz(d, SW, lb);
              ilo = lb;
              id = d[SW-1:0];
              it = n[3:0];
              iv = 1'b1;
              lat = 0;
              do begin
                tick();
                lat++;
                iv = 1'b0;
              end while (!ov && lat < 20);
              chk($sformatf("sweep_w%0d_p%0d_lat", SW, pe), lat, SS);
              chk($sformatf("sweep_w%0d_p%0d_count", SW, pe), oc, ec);
              chk($sformatf("sweep_w%0d_p%0d_all", SW, pe), oa, ec == SW);
              chk($sformatf("sweep_w%0d_p%0d_tag", SW, pe), ot, n[3:0]);
            end
          end
          sweep_done++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base, k;
    logic [31:0] d;
    bit lo;
    rst_l = 1'b0;
    sw_rst_l = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_lead_one = 1'b0;
    in_tag = '0;
    out_ready = 1'b1;
    lat_exact = 1'b1;
    chk_ready = 1'b0;
    bp = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_all", out_all, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 0);
    tick();
    rst_l = 1'b1;
    sw_rst_l = 1'b1;
    chk("in_ready_pre_edge", in_ready, 0);
    tick();
    chk("in_ready_post_edge", in_ready, 1);
    chk_ready = 1'b1;

    directed("lz_0x00010000", 32'h0001_0000, 1'b0, 4'd3, 15, 1'b0);
    directed("lz_zero", 32'h0000_0000, 1'b0, 4'd7, 32, 1'b1);
    directed("lo_ones", 32'hFFFF_FFFF, 1'b1, 4'd9, 32, 1'b1);
    directed("lz_msb", 32'h8000_0000, 1'b0, 4'd1, 0, 1'b0);
    directed("lo_0xFFF00000", 32'hFFF0_0000, 1'b1, 4'd12, 12, 1'b0);

    for (int i = 0; i < 24; i++) begin
      d = $urandom >> $urandom_range(0, 32);
      lo = ($urandom_range(0, 1) == 1);
      if (lo) d = ~d;
      send(d, lo, i[3:0]);
    end
    in_valid = 1'b0;
    repeat (6) tick();

    lat_exact = 1'b0;
    base = n_out;
    bp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      send(d, i[0], 4'(i + 2));
    end
    in_valid = 1'b0;
    k = 0;
    while ((q.size() != 0 || out_valid) && k < 200) begin
      tick();
      k++;
    end
    bp = 1'b0;
    chk("bp_drained", k < 200, 1);
    chk("bp_out_total", n_out - base, 8);
    tick();
    out_ready = 1'b1;
    lat_exact = 1'b1;
    tick();

    out_ready = 1'b0;
    send(32'h0000_00F0, 1'b0, 4'd4);
    send(32'h00F0_0000, 1'b0, 4'd5);
    send(32'hF000_0000, 1'b1, 4'd6);
    in_valid = 1'b0;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    flush = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h0000_0001;
    in_tag = 4'd8;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) chk("post_flush_valid", out_valid, 0);
    repeat (4) begin
      tick();
      chk("post_flush_valid_cyc", out_valid, 0);
    end

    send(32'h0000_1000, 1'b0, 4'd10);
    send(32'h0000_2000, 1'b0, 4'd11);
    send(32'h0000_4000, 1'b0, 4'd12);
    in_valid = 1'b0;
    chk("mid_out_valid", out_valid, 1);
    chk_ready = 1'b0;
    rst_l = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_all", out_all, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    tick();
    rst_l = 1'b1;
    tick();
    chk("rerst_in_ready", in_ready, 1);
    chk_ready = 1'b1;
    directed("post_rst", 32'h0000_0F00, 1'b0, 4'd5, 20, 1'b0);
    repeat (4) tick();
    chk("post_rst_no_extra", out_valid, 0);

    k = 0;
    while (sweep_done != 18 && k < 5000) begin
      tick();
      k++;
    end
    chk("sweep_complete", sweep_done, 18);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
